// File: rtl/mig_tt_enum.sv
// Programmable majority-inverter-graph evaluator that sweeps all 2^N_IN inputs into a truth table.
// Latency: start sampled at edge k -> busy for 2^N_IN cycles -> done pulse in cycle k+2^N_IN+1.
// Backpressure: none; start and config writes are dropped unless the block is idle.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   cfg_we, cfg_gate           write gate cfg_gate's operand selects/inversions
//   cfg_sel_a/b/c, cfg_inv     operand node selects and inversion mask {C,B,A}
//   cfg_out_we, cfg_out_sel,   write which node drives f and whether it is inverted
//   cfg_out_inv
//   start                      begin a sweep (single-cycle pulse)
//   busy, done, tt_valid, tt   sweep in progress, completion pulse, result-valid flag, truth table
module mig_tt_enum #(
    parameter int N_IN    = 7,
    parameter int N_GATES = 6,
    localparam int NODE_W = $clog2(1 + N_IN + N_GATES),
    localparam int GATE_W = $clog2(N_GATES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [GATE_W-1:0]    cfg_gate,
    input  logic [NODE_W-1:0]    cfg_sel_a,
    input  logic [NODE_W-1:0]    cfg_sel_b,
    input  logic [NODE_W-1:0]    cfg_sel_c,
    input  logic [2:0]           cfg_inv,
    input  logic                 cfg_out_we,
    input  logic [NODE_W-1:0]    cfg_out_sel,
    input  logic                 cfg_out_inv,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 tt_valid,
    output logic [2**N_IN-1:0]   tt
);

    localparam int NNODES = 1 + N_IN + N_GATES;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]        state;
    logic [N_IN-1:0]   cnt;

    logic [NODE_W-1:0] sel_a [N_GATES];
    logic [NODE_W-1:0] sel_b [N_GATES];
    logic [NODE_W-1:0] sel_c [N_GATES];
    logic [2:0]        inv   [N_GATES];
    logic [NODE_W-1:0] out_sel;
    logic              out_inv;

    logic              f;

    // Node read with a visibility limit: anything at or above lim (forward
    // references, self references, out-of-range selectors) reads as 0. This
    // is what keeps the programmable network loop-free.
    function automatic logic pick(input logic [NNODES-1:0] v,
                                  input logic [NODE_W-1:0] s,
                                  input int lim);
        return (int'(s) < lim) ? v[s] : 1'b0;
    endfunction

    // Evaluate the whole network for the current counter value in one cycle.
    // Gates are evaluated in index order so each one sees only settled
    // lower-numbered nodes.
    always_comb begin : eval
        logic [NNODES-1:0] nv;
        logic              a, b, c;
        nv = '0;
        a  = 1'b0;
        b  = 1'b0;
        c  = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            nv[1+k] = cnt[k];
        end
        for (int g = 0; g < N_GATES; g++) begin
            a = pick(nv, sel_a[g], N_IN + 1 + g) ^ inv[g][0];
            b = pick(nv, sel_b[g], N_IN + 1 + g) ^ inv[g][1];
            c = pick(nv, sel_c[g], N_IN + 1 + g) ^ inv[g][2];
            nv[N_IN+1+g] = (a & b) | (a & c) | (b & c);
        end
        f = pick(nv, out_sel, NNODES) ^ out_inv;
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            tt       <= '0;
            tt_valid <= 1'b0;
            out_sel  <= '0;
            out_inv  <= 1'b0;
            for (int g = 0; g < N_GATES; g++) begin
                sel_a[g] <= '0;
                sel_b[g] <= '0;
                sel_c[g] <= '0;
                inv[g]   <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    // Config writes land on the same edge that accepts a
                    // concurrent start, so the sweep sees the new network.
                    if (cfg_we && (int'(cfg_gate) < N_GATES)) begin
                        sel_a[cfg_gate] <= cfg_sel_a;
                        sel_b[cfg_gate] <= cfg_sel_b;
                        sel_c[cfg_gate] <= cfg_sel_c;
                        inv[cfg_gate]   <= cfg_inv;
                        tt_valid        <= 1'b0;
                    end
                    if (cfg_out_we) begin
                        out_sel  <= cfg_out_sel;
                        out_inv  <= cfg_out_inv;
                        tt_valid <= 1'b0;
                    end
                    if (start) begin
                        state    <= S_RUN;
                        cnt      <= '0;
                        tt_valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    tt[cnt] <= f;
                    cnt     <= cnt + 1'b1;
                    // Counter wrap is the exit: the last bit is written on
                    // the same edge that moves to FIN.
                    if (cnt == '1) begin
                        state    <= S_FIN;
                        tt_valid <= 1'b1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mig_tt_enum.sv
// Testbench for mig_tt_enum: directed table vectors, multi-cycle corner cases, randomized networks.
// Latency: each sweep takes 2^N_IN+1 clocks after the start edge.
// Backpressure: none; stimulus is only applied while the DUT is idle except in the disturbance cases.
module tb_mig_tt_enum;

    localparam int N_IN    = 7;
    localparam int N_GATES = 6;
    localparam int NNODES  = 14;

    logic         clk;
    logic         rst_n;
    logic         cfg_we;
    logic [2:0]   cfg_gate;
    logic [3:0]   cfg_sel_a;
    logic [3:0]   cfg_sel_b;
    logic [3:0]   cfg_sel_c;
    logic [2:0]   cfg_inv;
    logic         cfg_out_we;
    logic [3:0]   cfg_out_sel;
    logic         cfg_out_inv;
    logic         start;
    logic         busy;
    logic         done;
    logic         tt_valid;
    logic [127:0] tt;

    mig_tt_enum dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_gate    (cfg_gate),
        .cfg_sel_a   (cfg_sel_a),
        .cfg_sel_b   (cfg_sel_b),
        .cfg_sel_c   (cfg_sel_c),
        .cfg_inv     (cfg_inv),
        .cfg_out_we  (cfg_out_we),
        .cfg_out_sel (cfg_out_sel),
        .cfg_out_inv (cfg_out_inv),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .tt_valid    (tt_valid),
        .tt          (tt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference configuration, as software believes it was loaded.
    int m_sa [N_GATES];
    int m_sb [N_GATES];
    int m_sc [N_GATES];
    int m_inv[N_GATES];
    int m_os;
    int m_oi;

    typedef struct {
        int           sa, sb, sc, inv, os, oi;
        logic [127:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < N_GATES; g++) begin
            m_sa[g] = 0; m_sb[g] = 0; m_sc[g] = 0; m_inv[g] = 0;
        end
        m_os = 0;
        m_oi = 0;
    endtask

    // Truth table straight from the node-numbering rules: majority is
    // "at least two of three operands are 1".
    function automatic logic [127:0] model_tt();
        logic [127:0] r;
        int nd[NNODES];
        int a, b, c, lim, v;
        r = '0;
        for (int i = 0; i < 128; i++) begin
            nd[0] = 0;
            for (int k = 0; k < N_IN; k++) nd[1+k] = (i >> k) & 1;
            for (int g = 0; g < N_GATES; g++) begin
                lim = N_IN + 1 + g;
                a = ((m_sa[g] < lim) ? nd[m_sa[g]] : 0) ^ (m_inv[g] & 1);
                b = ((m_sb[g] < lim) ? nd[m_sb[g]] : 0) ^ ((m_inv[g] >> 1) & 1);
                c = ((m_sc[g] < lim) ? nd[m_sc[g]] : 0) ^ ((m_inv[g] >> 2) & 1);
                nd[lim] = (a + b + c >= 2) ? 1 : 0;
            end
            v = ((m_os < NNODES) ? nd[m_os] : 0) ^ m_oi;
            r[i] = (v != 0);
        end
        return r;
    endfunction

    task automatic write_gate(input int g, input int sa, input int sb, input int sc, input int iv);
        cfg_we    = 1'b1;
        cfg_gate  = 3'(g);
        cfg_sel_a = 4'(sa);
        cfg_sel_b = 4'(sb);
        cfg_sel_c = 4'(sc);
        cfg_inv   = 3'(iv);
        @(negedge clk);
        cfg_we = 1'b0;
        if (g < N_GATES) begin
            m_sa[g] = sa; m_sb[g] = sb; m_sc[g] = sc; m_inv[g] = iv;
        end
    endtask

    task automatic write_out(input int os, input int oi);
        cfg_out_we  = 1'b1;
        cfg_out_sel = 4'(os);
        cfg_out_inv = oi[0];
        @(negedge clk);
        cfg_out_we = 1'b0;
        m_os = os;
        m_oi = oi;
    endtask

    // Start a sweep (optionally with an output write in the same cycle),
    // then check busy length, single done pulse, tt_valid and the table.
    task automatic sweep_check(input string nm, input logic [127:0] exp,
                               input bit ow, input int os, input int oi);
        int busy_n, cyc;
        start = 1'b1;
        if (ow) begin
            cfg_out_we  = 1'b1;
            cfg_out_sel = 4'(os);
            cfg_out_inv = oi[0];
        end
        @(negedge clk);
        start      = 1'b0;
        cfg_out_we = 1'b0;
        busy_n = 0;
        cyc    = 0;
        while (!done && cyc < 400) begin
            if (busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
        chk({nm, " done_seen"}, 128'(done), 128'(1));
        chk({nm, " busy_cycles"}, 128'(busy_n), 128'(128));
        chk({nm, " busy_in_fin"}, 128'(busy), 128'(0));
        chk({nm, " tt_valid"}, 128'(tt_valid), 128'(1));
        chk({nm, " tt"}, tt, exp);
        @(negedge clk);
        chk({nm, " done_single"}, 128'(done), 128'(0));
    endtask

    vec_t vecs[8];

    initial begin
        logic [127:0] exp_v, prev_tt;
        int dn;

        vecs[0] = '{1, 2, 3, 0, 8, 0, {16{8'hE8}}};
        vecs[1] = '{1, 2, 3, 0, 8, 1, {16{8'h17}}};
        vecs[2] = '{1, 2, 3, 0, 1, 0, {16{8'hAA}}};
        vecs[3] = '{1, 2, 3, 0, 0, 1, {128{1'b1}}};
        vecs[4] = '{1, 2, 9, 0, 8, 0, {16{8'h88}}};
        vecs[5] = '{1, 2, 0, 4, 8, 0, {16{8'hEE}}};
        vecs[6] = '{1, 2, 3, 0, 15, 0, 128'h0};
        vecs[7] = '{1, 2, 3, 0, 7, 0, {{64{1'b1}}, {64{1'b0}}}};

        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_gate = '0; cfg_sel_a = '0; cfg_sel_b = '0; cfg_sel_c = '0;
        cfg_inv = '0; cfg_out_we = 1'b0; cfg_out_sel = '0; cfg_out_inv = 1'b0; start = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset done", 128'(done), 128'(0));
        chk("reset tt_valid", 128'(tt_valid), 128'(0));
        chk("reset tt", tt, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unconfigured network: every gate and f read constant 0.
        sweep_check("noconfig", 128'h0, 1'b0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            write_gate(0, vecs[i].sa, vecs[i].sb, vecs[i].sc, vecs[i].inv);
            chk($sformatf("vec%0d cfg_clears_valid", i), 128'(tt_valid), 128'(0));
            write_out(vecs[i].os, vecs[i].oi);
            sweep_check($sformatf("vec%0d", i), vecs[i].exp, 1'b0, 0, 0);
        end

        // Config write in idle: tt_valid drops, tt retained.
        prev_tt = tt;
        write_gate(1, 4, 8, 5, 1);
        chk("cfgwr valid_cleared", 128'(tt_valid), 128'(0));
        chk("cfgwr tt_retained", tt, prev_tt);

        // Output write coinciding with start must be used by the sweep.
        write_gate(0, 1, 2, 3, 0);
        m_os = 9; m_oi = 1;
        sweep_check("start_with_cfg", model_tt(), 1'b1, 9, 1);

        // Start and cfg_we pulsed 50 cycles into RUN are both ignored.
        exp_v = model_tt();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        for (int c = 1; c < 160; c++) begin
            if (c == 50) begin
                start = 1'b1; cfg_we = 1'b1; cfg_gate = 3'd0;
                cfg_sel_a = 4'd7; cfg_sel_b = 4'd6; cfg_sel_c = 4'd5; cfg_inv = 3'd7;
            end else begin
                start = 1'b0; cfg_we = 1'b0;
            end
            if (done) dn++;
            @(negedge clk);
        end
        chk("midsweep done_count", 128'(dn), 128'(1));
        chk("midsweep tt", tt, exp_v);
        chk("midsweep still_idle", 128'(busy), 128'(0));
        sweep_check("midsweep cfg_kept", exp_v, 1'b0, 0, 0);

        // Reset 60 cycles into RUN aborts the sweep with no done pulse.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (59) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort busy", 128'(busy), 128'(0));
        chk("abort tt_valid", 128'(tt_valid), 128'(0));
        chk("abort tt", tt, 128'h0);
        chk("abort done", 128'(done), 128'(0));
        dn = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (done || busy) dn++;
        end
        chk("abort no_activity", 128'(dn), 128'(0));
        write_gate(0, 1, 2, 3, 0);
        write_out(8, 0);
        sweep_check("after_abort", {16{8'hE8}}, 1'b0, 0, 0);

        // Random networks, each with a write to a nonexistent gate index.
        for (int it = 0; it < 20; it++) begin
            for (int g = 0; g < N_GATES; g++) begin
                write_gate(g, $urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 15), $urandom_range(0, 7));
            end
            write_gate($urandom_range(6, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 15), $urandom_range(0, 7));
            write_out($urandom_range(0, 15), $urandom_range(0, 1));
            sweep_check($sformatf("rand%0d", it), model_tt(), 1'b0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
